// File: rtl/dec_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dec_filter_pkg
//  Brief    : Shared constants, FSM state type and saturation helper for the
//             decimate-by-2 half-band filter.
//  Revision : 1.0  initial release
// ============================================================================
package dec_filter_pkg;

  localparam int COEF_W    = 18;
  localparam int HB_NTAPS  = 11;
  localparam int HB_CENTER = 5;
  localparam int HB_FRAC   = COEF_W - 1;

  localparam logic signed [COEF_W-1:0] HB_C0 = 18'sd1206;
  localparam logic signed [COEF_W-1:0] HB_C2 = -18'sd8937;
  localparam logic signed [COEF_W-1:0] HB_C4 = 18'sd40499;
  localparam logic signed [COEF_W-1:0] HB_CC = 18'sd65536;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC0  = 3'd1,
    MAC1  = 3'd2,
    MAC2  = 3'd3,
    ROUND = 3'd4
  } hb_state_t;

  // Clamp v into the signed range of a w-bit word (w <= 64).
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/halfband_dec2_preadd_mac.sv
`default_nettype none
// ============================================================================
//  Module   : preadd_mac
//  Brief    : Symmetric pre-adder, single multiplier and accumulator with
//             clear / load / enable controls (clear > load > enable).
//  Revision : 1.0  initial release
// ============================================================================
module preadd_mac #(
  parameter int IN_W   = 33,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic signed [ACC_W-1:0]  i_load_val,
  input  logic                     i_en,
  input  logic signed [IN_W-1:0]   i_a,
  input  logic signed [IN_W-1:0]   i_b,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int P_W = IN_W + 1 + COEF_W;

  logic signed [IN_W:0]      w_sum;
  logic signed [P_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_sum  = (IN_W+1)'(i_a) + (IN_W+1)'(i_b);
  assign w_prod = P_W'(w_sum) * P_W'(i_coef);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/halfband_dec2.sv
`default_nettype none
// ============================================================================
//  Module   : halfband_dec2
//  Brief    : 11-tap half-band FIR with decimate-by-2, one shared multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module halfband_dec2 #(
  parameter int IN_W   = 33,
  parameter int OUT_W  = 33,
  parameter int COEF_W = dec_filter_pkg::COEF_W,
  parameter int ACC_W  = 54
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid,
  output logic                    overrun
);

  import dec_filter_pkg::*;

  logic signed [IN_W-1:0]   r_d [HB_NTAPS];
  logic                     r_phase;
  hb_state_t                r_state;
  hb_state_t                w_next;
  logic                     w_accept;
  logic                     w_start;
  logic                     w_mac_en;
  logic                     w_clear;
  logic signed [IN_W-1:0]   w_a;
  logic signed [IN_W-1:0]   w_b;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_load_val;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_out_valid;
  logic                     r_overrun;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_mac_en = 1'b0;
    w_clear  = 1'b0;
    w_a      = r_d[0];
    w_b      = r_d[HB_NTAPS-1];
    w_coef   = COEF_W'(HB_C0);
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (r_phase) begin
            w_start = 1'b1;
            w_next  = MAC0;
          end
        end
      end
      MAC0: begin
        w_mac_en = 1'b1;
        w_next   = MAC1;
      end
      MAC1: begin
        w_a      = r_d[2];
        w_b      = r_d[8];
        w_coef   = COEF_W'(HB_C2);
        w_mac_en = 1'b1;
        w_next   = MAC2;
      end
      MAC2: begin
        w_a      = r_d[4];
        w_b      = r_d[6];
        w_coef   = COEF_W'(HB_C4);
        w_mac_en = 1'b1;
        w_next   = ROUND;
      end
      ROUND: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HB_NTAPS; k++) r_d[k] <= '0;
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_d[0] <= in;
      for (int k = 1; k < HB_NTAPS; k++) r_d[k] <= r_d[k-1];
      r_phase <= ~r_phase;
    end
  end

  // Centre tap is exactly 0.5 (HB_CC), so it seeds the accumulator as a shift
  // of the sample that lands in the centre position on the trigger edge.
  assign w_load_val = ACC_W'(r_d[HB_CENTER-1]) <<< (HB_FRAC - 1);

  preadd_mac #(
    .IN_W   (IN_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_load     (w_start),
    .i_load_val (w_load_val),
    .i_en       (w_mac_en),
    .i_a        (w_a),
    .i_b        (w_b),
    .i_coef     (w_coef),
    .o_acc      (w_acc)
  );

  assign w_rnd = (w_acc + (ACC_W'(1) <<< (HB_FRAC - 1))) >>> HB_FRAC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= (r_state == ROUND);
      if (r_state == ROUND) r_out <= OUT_W'(sat_w(64'(w_rnd), OUT_W));
      if (in_valid && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_halfband_dec2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_halfband_dec2
//  Brief    : Scoreboard bench for halfband_dec2 with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_halfband_dec2;

  localparam logic signed [32:0] SAT_P = 33'h0_FFFF_FFFF;
  localparam logic signed [32:0] SAT_N = 33'h1_0000_0000;

  typedef struct {
    logic signed [32:0] val;
    bit                 chk;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [32:0] in_s = '0;
  logic               in_valid = 1'b0;
  logic signed [32:0] out_s;
  logic               out_valid;
  logic               overrun;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   tb_phase = 1'b0;

  int ev_exp [6] = '{0, 0, 65536, 0, 0, 0};
  int od_exp [7] = '{1206, -8937, 40499, 40499, -8937, 1206, 0};
  int dc_exp [8] = '{9, -59, 750, 1059, 991, 1000, 1000, 1000};
  logic signed [32:0] sat_seq [12];

  halfband_dec2 dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .in_valid  (in_valid),
    .out       (out_s),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) check("out_value", out_s, mon_e.val);
        check("out_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send(input logic signed [32:0] x, input logic signed [32:0] e,
                      input bit chk, input int gap);
    @(negedge clk);
    in_s = x; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_s = '0;
    if (tb_phase) sb_q.push_back('{val: e, chk: chk, cyc: cyc + 4});
    tb_phase = ~tb_phase;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    tb_phase = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sat_seq = '{'0, SAT_P, '0, SAT_N, '0, SAT_P, SAT_P, SAT_P, '0, SAT_N, '0, SAT_P};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_outputs", {out_s, out_valid, overrun}, 0);
    end

    for (int i = 0; i < 12; i++) send(i == 0 ? 33'sd131072 : 33'sd0, ev_exp[i/2], 1'b1, 8);
    drain();

    do_reset();
    for (int i = 0; i < 14; i++) send(i == 1 ? 33'sd131072 : 33'sd0, od_exp[i/2], 1'b1, 8);
    drain();

    do_reset();
    for (int i = 0; i < 16; i++) send(33'sd1000, dc_exp[i/2], 1'b1, 8);
    drain();

    do_reset();
    for (int i = 0; i < 12; i++) send(sat_seq[i], SAT_P, i == 11, 8);
    drain();

    do_reset();
    for (int i = 0; i < 12; i++)
      send(sat_seq[i] == SAT_P ? SAT_N : (sat_seq[i] == SAT_N ? SAT_P : sat_seq[i]),
           SAT_N, i == 11, 8);
    drain();

    // Overrun: extra sample during MAC1 must be dropped without shifting.
    do_reset();
    send(33'sd0, 33'sd0, 1'b0, 8);
    @(negedge clk);
    in_s = 33'sd131072; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sb_q.push_back('{val: 33'sd1206, chk: 1'b1, cyc: cyc + 4});
    tb_phase = 1'b0;
    check("overrun_before", overrun, 0);
    @(negedge clk);
    in_s = 33'sd777777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_s = '0;
    check("overrun_set", overrun, 1);
    repeat (6) @(negedge clk);
    send(33'sd0, 33'sd0, 1'b0, 8);
    send(33'sd0, -33'sd8937, 1'b1, 8);
    drain();
    check("overrun_sticky", overrun, 1);

    // Reset asserted while the FSM is in MAC1.
    send(33'sd0, 33'sd0, 1'b0, 8);
    @(negedge clk);
    in_s = 33'sd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_s = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_phase = 1'b0;
    check("midreset_outputs", {out_s, out_valid, overrun}, 0);
    repeat (12) @(negedge clk);
    check("midreset_quiet", {out_s, out_valid, overrun}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
